// File: rtl/serial_shifter_if.sv
// Request/result bundle for the iterative shifter.
// master: requester side (drives the operand request and accepts the result).
// slave:  shifter side (accepts the request and presents the result).
//
// Signals:
//   i_valid/o_ready           request handshake
//   i_data/i_amount/i_sel     operand, unsigned shift amount, op select
//   o_valid/i_ready           result handshake
//   o_result                  shifted result
interface serial_shifter_if #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) ();

  logic               i_valid;
  logic               o_ready;
  logic [XLEN-1:0]    i_data;
  logic [SHAMT_W-1:0] i_amount;
  logic [1:0]         i_sel;
  logic               o_valid;
  logic               i_ready;
  logic [XLEN-1:0]    o_result;

  modport master (
    output i_valid, i_data, i_amount, i_sel, i_ready,
    input  o_ready, o_valid, o_result
  );

  modport slave (
    input  i_valid, i_data, i_amount, i_sel, i_ready,
    output o_ready, o_valid, o_result
  );

endinterface

// File: rtl/serial_shifter.sv
// Purpose:      multi-cycle SLL/SRL/SRA shifter, one bit position per clock.
// Latency:      o_valid rises N edges after the accept edge (N = amount; 0 for
//               amount 0 or the reserved select), one bubble back to idle.
// Backpressure: result held stable in DONE until i_ready; no new request is
//               taken (o_ready=0) until the result handshake completes.
//
// Ports:
//   i_clk     clock, rising edge
//   i_reset   asynchronous active-high reset
//   bus       serial_shifter_if.slave: i_valid/o_ready request handshake,
//             i_data/i_amount/i_sel operands, o_valid/i_ready result
//             handshake, o_result
//
// Select encoding: 00 SRL, 01 SRA, 11 SLL, 10 reserved (pass-through).
module serial_shifter #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic            i_clk,
  input  logic            i_reset,
  serial_shifter_if.slave bus
);

  localparam logic [1:0] SEL_SRL = 2'b00;
  localparam logic [1:0] SEL_SRA = 2'b01;
  localparam logic [1:0] SEL_RSV = 2'b10;
  localparam logic [1:0] SEL_SLL = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [XLEN-1:0]    shreg;
  logic [XLEN-1:0]    shreg_step;
  logic [SHAMT_W-1:0] cnt;
  logic [1:0]         op;
  logic               accept;

  // A request is only taken in IDLE; o_ready is a pure function of state so
  // the upstream never sees a combinational loop through i_valid.
  assign accept = (state == IDLE) && bus.i_valid;

  // One-bit step of the captured operation. SRA replicates the current MSB,
  // which after any number of steps is still the original operand's sign.
  always_comb begin
    shreg_step = shreg;
    case (op)
      SEL_SRL: shreg_step = {1'b0, shreg[XLEN-1:1]};
      SEL_SRA: shreg_step = {shreg[XLEN-1], shreg[XLEN-1:1]};
      SEL_SLL: shreg_step = {shreg[XLEN-2:0], 1'b0};
      default: shreg_step = shreg;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        // Zero amount and the reserved select skip SHIFT entirely, so the
        // loaded operand is presented unchanged on the next cycle.
        if (bus.i_valid) begin
          if ((bus.i_amount != '0) && (bus.i_sel != SEL_RSV)) begin
            state_nxt = SHIFT;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      SHIFT: begin
        // cnt==1 means this edge performs the last step.
        if (cnt == SHAMT_W'(1)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.i_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (decoded from state only)
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.o_ready  = (state == IDLE);
    bus.o_valid  = (state == DONE);
    bus.o_result = shreg;
  end

  // ---------------------------------------------------------------------------
  // Datapath: operand capture and iterative shift
  // ---------------------------------------------------------------------------
  // Operands are sampled only on the accept edge; in DONE everything holds so
  // the result stays stable under backpressure. cnt is only decremented in
  // SHIFT, where it is always >= 1, so it cannot wrap.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      shreg <= '0;
      cnt   <= '0;
      op    <= SEL_SRL;
    end else if (accept) begin
      shreg <= bus.i_data;
      cnt   <= bus.i_amount;
      op    <= bus.i_sel;
    end else if (state == SHIFT) begin
      shreg <= shreg_step;
      cnt   <= cnt - SHAMT_W'(1);
    end
  end

endmodule
